// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule engine: streams w[0]..w[Nw-1] one word per cycle over
// valid/ready, keeping only the last Nk words in a sliding window.

module S_BOX (
    output logic [7:0] sbox_out,
    input  logic [7:0] sbox_in
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_hi;

    // Entry 0 sits in the top byte of the table.
    assign bit_hi   = 11'd2047 - {sbox_in, 3'b000};
    assign sbox_out = SBOX_TBL[bit_hi -: 8];
endmodule

module aes_key_expander #(
    parameter int MAX_KEY = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         key_len,
    input  logic [MAX_KEY-1:0] key,
    output logic               wd_valid,
    input  logic               wd_ready,
    output logic [31:0]        wd_data,
    output logic [5:0]         wd_idx,
    output logic               wd_last,
    output logic               busy,
    output logic               done,
    output logic               err
);
    // state    | meaning
    // IDLE     | waiting for start; illegal key_len pulses err
    // EMIT_KEY | presenting key words w[0]..w[Nk-1] straight from the window
    // EXPAND   | presenting computed words w[Nk]..w[Nw-1]

    typedef enum logic [1:0] {IDLE, EMIT_KEY, EXPAND} state_t;

    state_t      state, state_nxt;
    logic [31:0] win [8];
    logic [31:0] win_nxt [8];
    logic [2:0]  j, j_nxt, j_adv;
    logic [7:0]  rcon, rcon_nxt, rcon_x;
    logic [1:0]  klen, klen_nxt;
    logic        wd_valid_nxt, wd_last_nxt, busy_nxt, done_nxt, err_nxt;
    logic [31:0] wd_data_nxt;
    logic [5:0]  wd_idx_nxt, idx_inc;

    logic [255:0] key_pad;
    logic         start_legal;
    logic [2:0]   nk_m1;
    logic [5:0]   nw_m1;
    logic         hs;
    logic         take_new;
    logic [31:0]  last_word, sub_in, sub_out, temp, new_word;

    assign key_pad = 256'(key) << (256 - MAX_KEY);
    assign hs      = wd_valid & wd_ready;
    assign idx_inc = wd_idx + 6'd1;
    assign j_adv   = (j == nk_m1) ? 3'd0 : j + 3'd1;
    assign rcon_x  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        case (key_len)
            2'd0:    start_legal = (MAX_KEY >= 128);
            2'd1:    start_legal = (MAX_KEY >= 192);
            2'd2:    start_legal = (MAX_KEY >= 256);
            default: start_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (klen)
            2'd0:    begin nk_m1 = 3'd3; nw_m1 = 6'd43; end
            2'd1:    begin nk_m1 = 3'd5; nw_m1 = 6'd51; end
            default: begin nk_m1 = 3'd7; nw_m1 = 6'd59; end
        endcase
    end

    // j_adv is the position (i mod Nk) of the word being computed; win[0] is w[i-Nk].
    assign last_word = win[nk_m1];
    assign sub_in    = (j_adv == 3'd0) ? {last_word[23:0], last_word[31:24]} : last_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        S_BOX u_sbox (
            .sbox_out (sub_out[8*b +: 8]),
            .sbox_in  (sub_in[8*b +: 8])
        );
    end

    always_comb begin
        if (j_adv == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nk_m1 == 3'd7 && j_adv == 3'd4)
            temp = sub_out;
        else
            temp = last_word;
    end

    assign new_word = win[0] ^ temp;

    always_comb begin
        state_nxt    = state;
        win_nxt      = win;
        j_nxt        = j;
        rcon_nxt     = rcon;
        klen_nxt     = klen;
        wd_valid_nxt = wd_valid;
        wd_data_nxt  = wd_data;
        wd_idx_nxt   = wd_idx;
        wd_last_nxt  = wd_last;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        take_new     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        for (int k = 0; k < 8; k++)
                            win_nxt[k] = key_pad[255-32*k -: 32];
                        klen_nxt     = key_len;
                        j_nxt        = 3'd0;
                        rcon_nxt     = 8'h01;
                        wd_valid_nxt = 1'b1;
                        wd_data_nxt  = key_pad[255 -: 32];
                        wd_idx_nxt   = 6'd0;
                        wd_last_nxt  = 1'b0;
                        busy_nxt     = 1'b1;
                        state_nxt    = EMIT_KEY;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            EMIT_KEY: begin
                if (hs) begin
                    wd_idx_nxt = idx_inc;
                    j_nxt      = j_adv;
                    if (j == nk_m1) begin
                        take_new  = 1'b1;
                        state_nxt = EXPAND;
                    end else begin
                        wd_data_nxt = win[j_adv];
                    end
                end
            end
            EXPAND: begin
                if (hs) begin
                    if (wd_last) begin
                        wd_valid_nxt = 1'b0;
                        wd_data_nxt  = 32'h0;
                        wd_idx_nxt   = 6'd0;
                        wd_last_nxt  = 1'b0;
                        busy_nxt     = 1'b0;
                        done_nxt     = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        take_new    = 1'b1;
                        wd_idx_nxt  = idx_inc;
                        j_nxt       = j_adv;
                        wd_last_nxt = (idx_inc == nw_m1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Slide the window by one and append the freshly computed word at Nk-1.
        if (take_new) begin
            wd_data_nxt = new_word;
            for (int k = 0; k < 7; k++)
                win_nxt[k] = (3'(k) == nk_m1) ? new_word : win[k+1];
            win_nxt[7] = new_word;
            if (j_adv == 3'd0)
                rcon_nxt = rcon_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            win      <= '{default: 32'h0};
            j        <= 3'd0;
            rcon     <= 8'h0;
            klen     <= 2'd0;
            wd_valid <= 1'b0;
            wd_data  <= 32'h0;
            wd_idx   <= 6'd0;
            wd_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            win      <= win_nxt;
            j        <= j_nxt;
            rcon     <= rcon_nxt;
            klen     <= klen_nxt;
            wd_valid <= wd_valid_nxt;
            wd_data  <= wd_data_nxt;
            wd_idx   <= wd_idx_nxt;
            wd_last  <= wd_last_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using the FIPS-197 key expansion vectors.

module tb_aes_key_expander;
    logic         clk = 1'b0;
    logic         rst_n, start, wd_ready;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         wd_valid, wd_last, busy, done, err;
    logic [31:0]  wd_data;
    logic [5:0]   wd_idx;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] got [64];
    bit seq_ok, stable_ok;
    int hs_cnt, stall_cnt, last_cyc;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_expander #(.MAX_KEY(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key      (key),
        .wd_valid (wd_valid),
        .wd_ready (wd_ready),
        .wd_data  (wd_data),
        .wd_idx   (wd_idx),
        .wd_last  (wd_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_got();
        for (int k = 0; k < 64; k++) got[k] = 32'h0;
    endtask

    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        start   = 1'b1;
        key_len = kl;
        key     = k;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Consumes words from the current cycle on, until stop_hs handshakes or the budget runs out.
    task automatic run_stream(input int nw, input int stop_hs, input bit rnd);
        int          c = 1;
        bit          have_prev = 1'b0;
        bit          rdy;
        logic [31:0] pd;
        logic [5:0]  pi;
        logic        pl;
        hs_cnt = 0; stall_cnt = 0; last_cyc = 0; seq_ok = 1'b1; stable_ok = 1'b1;
        while (hs_cnt < stop_hs && c < 1000) begin
            if (wd_valid !== 1'b1) seq_ok = 1'b0;
            if (have_prev && (wd_data !== pd || wd_idx !== pi || wd_last !== pl)) stable_ok = 1'b0;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wd_ready = rdy;
            if (rdy) begin
                got[wd_idx] = wd_data;
                if (int'(wd_idx) != hs_cnt || wd_last !== (hs_cnt == nw - 1)) seq_ok = 1'b0;
                hs_cnt++;
                last_cyc  = c;
                have_prev = 1'b0;
            end else begin
                stall_cnt++;
                have_prev = 1'b1;
                pd = wd_data; pi = wd_idx; pl = wd_last;
            end
            @(negedge clk);
            c++;
        end
        wd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key = '0; wd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, wd_valid, wd_last, done, err}, 0);
        chk("rst_data", wd_data, 0);
        chk("rst_idx", wd_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128, ready always high
        clear_got();
        do_start(2'd0, KEY128);
        chk("a128_first", {busy, wd_valid}, 2'b11);
        chk("a128_w0_live", wd_data, 32'h2b7e1516);
        chk("a128_idx0", wd_idx, 0);
        run_stream(44, 44, 1'b0);
        chk("a128_hs", hs_cnt, 44);
        chk("a128_last_cycle", last_cyc, 44);
        chk("a128_seq", seq_ok, 1);
        chk("a128_w4", got[4], 32'ha0fafe17);
        chk("a128_w5", got[5], 32'h88542cb1);
        chk("a128_w40", got[40], 32'hd014f9a8);
        chk("a128_w43", got[43], 32'hb6630ca6);
        chk("a128_done", {done, busy, wd_valid}, 3'b100);

        // AES-192 started in the done cycle
        clear_got();
        do_start(2'd1, KEY192);
        chk("a192_b2b_start", {busy, wd_valid, done}, 3'b110);
        chk("a192_w0_live", wd_data, 32'h8e73b0f7);
        run_stream(52, 52, 1'b0);
        chk("a192_hs", hs_cnt, 52);
        chk("a192_seq", seq_ok, 1);
        chk("a192_w6", got[6], 32'hfe0c91f7);
        chk("a192_w51", got[51], 32'h01002202);
        chk("a192_done", {done, busy, wd_valid}, 3'b100);
        @(negedge clk);
        chk("a192_done_pulse", {done, busy, wd_valid}, 3'b000);

        // AES-256
        clear_got();
        do_start(2'd2, KEY256);
        run_stream(60, 60, 1'b0);
        chk("a256_hs", hs_cnt, 60);
        chk("a256_seq", seq_ok, 1);
        chk("a256_w0", got[0], 32'h603deb10);
        chk("a256_w8", got[8], 32'h9ba35411);
        chk("a256_w12_subword", got[12], 32'ha8b09c1a);
        chk("a256_w59", got[59], 32'h706c631e);
        chk("a256_done", {done, busy, wd_valid}, 3'b100);
        @(negedge clk);

        // AES-128 under random backpressure
        clear_got();
        do_start(2'd0, KEY128);
        run_stream(44, 44, 1'b1);
        chk("stall_hs", hs_cnt, 44);
        chk("stall_cycles", last_cyc, 44 + stall_cnt);
        chk("stall_seq", seq_ok, 1);
        chk("stall_stable", stable_ok, 1);
        chk("stall_w4", got[4], 32'ha0fafe17);
        chk("stall_w40", got[40], 32'hd014f9a8);
        chk("stall_w43", got[43], 32'hb6630ca6);
        chk("stall_done", {done, busy, wd_valid}, 3'b100);
        @(negedge clk);

        // Illegal key_len
        do_start(2'd3, KEY128);
        chk("illegal_err", {err, busy, wd_valid}, 3'b100);
        @(negedge clk);
        chk("illegal_after", {err, busy, wd_valid}, 3'b000);

        // Start while busy is ignored
        clear_got();
        do_start(2'd0, KEY128);
        wd_ready = 1'b0;
        start = 1'b1; key_len = 2'd3;
        @(negedge clk);
        chk("busy_start_no_err", {err, busy, wd_valid}, 3'b011);
        chk("busy_start_idx", wd_idx, 0);
        key_len = 2'd2; key = KEY256;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_hold", wd_data, 32'h2b7e1516);
        run_stream(44, 44, 1'b0);
        chk("busy_start_hs", hs_cnt, 44);
        chk("busy_start_seq", seq_ok, 1);
        chk("busy_start_w43", got[43], 32'hb6630ca6);
        @(negedge clk);

        // Reset in the middle of an AES-256 stream, then a fresh AES-128 run
        clear_got();
        do_start(2'd2, KEY256);
        run_stream(60, 21, 1'b0);
        chk("mid_hs", hs_cnt, 21);
        chk("mid_w12", got[12], 32'ha8b09c1a);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {busy, wd_valid, wd_last, done, err}, 0);
        chk("mid_rst_data", wd_data, 0);
        chk("mid_rst_idx", wd_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_got();
        do_start(2'd0, KEY128);
        chk("post_rst_w0_live", wd_data, 32'h2b7e1516);
        run_stream(44, 44, 1'b0);
        chk("post_rst_hs", hs_cnt, 44);
        chk("post_rst_last_cycle", last_cyc, 44);
        chk("post_rst_seq", seq_ok, 1);
        chk("post_rst_w4", got[4], 32'ha0fafe17);
        chk("post_rst_w43", got[43], 32'hb6630ca6);
        chk("post_rst_done", {done, busy, wd_valid}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
